// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
// Central round-robin arbiter for a shared PCI bus. Grants are active-low,
// registered and one-hot. The bus parks on PARK_MASTER when nobody requests.
// Every change of ownership passes through a one-cycle all-released GAP so
// that two agents never drive the tri-stated bus at the same time.
//
// Optional feature, enabled by defining PCI_ARB_TIMEOUT_EN:
//   A granted master that has not started a transaction loses its grant
//   after TIMEOUT_CYC idle-bus cycles. Without the macro, a granted silent
//   master keeps the grant for as long as its REQ_n stays low.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int PARK_MASTER = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         REQ_n,
  input  logic                         FRAME_n,
  input  logic                         IRDY_n,
  output logic [N_MASTERS-1:0]         GNT_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_vld
);

  localparam int                   OW       = $clog2(N_MASTERS);
  localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_MASTER);
  localparam logic [OW-1:0]        LAST_RST = OW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] PARK_BIT = N_MASTERS'(1) << PARK_MASTER;

  // Reject parameter sets the arbiter cannot honour.
  if (N_MASTERS < 2 || N_MASTERS > 8 || PARK_MASTER < 0 ||
      PARK_MASTER >= N_MASTERS || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("pci_bus_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nobody granted, nobody driving
    S_PARK = 2'd1,  // bus parked on PARK_MASTER
    S_OWN  = 2'd2,  // granted to owner_q after arbitration
    S_GAP  = 2'd3   // turnaround cycle, all grants released
  } state_e;

  // First requester found scanning upward from last+1, wrapping around.
  function automatic logic [OW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [OW-1:0]        last);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    pick = last;
    // Walk from the farthest candidate down to the nearest so the nearest wins.
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = OW'((int'(last) + k) % N_MASTERS);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // One-hot mask of a master index.
  function automatic logic [N_MASTERS-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_MASTERS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [OW-1:0]        pend_q, pend_d;
  logic                 pend_park_q, pend_park_d;
  logic                 tx_q, tx_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic                 vld_q, vld_d;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] owner_bit;
  logic [N_MASTERS-1:0] arb_req;
  logic [OW-1:0]        win;
  logic                 tx_now;
  logic                 rearb;
  logic                 timed_out;

  assign req       = ~REQ_n;
  assign owner_bit = onehot(owner_q);
  // A transaction counts as started from the edge that first sees FRAME_n low.
  assign tx_now    = tx_q | ~FRAME_n;

`ifdef PCI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_idle;
  assign bus_idle = FRAME_n & IRDY_n;
`else
  // IRDY_n only matters for the idle-timeout feature.
  logic irdy_unused;
  assign irdy_unused = IRDY_n;
`endif

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    pend_d      = pend_q;
    pend_park_d = pend_park_q;
    tx_d        = tx_q;
    arb_req     = req;
    win         = owner_q;
    rearb       = 1'b0;
    timed_out   = 1'b0;
`ifdef PCI_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Nothing is driving, so a winner can be granted without a gap.
        if (|req) begin
          win     = rr_pick(req, last_q);
          state_d = S_OWN;
          owner_d = win;
          last_d  = win;
        end else begin
          state_d = S_PARK;
          owner_d = PARK_IDX;
        end
      end

      S_PARK: begin
        if (req == PARK_BIT) begin
          // Parked master asks for the bus it already holds: grant stays low.
          state_d = S_OWN;
          owner_d = PARK_IDX;
          last_d  = PARK_IDX;
        end else if (|req) begin
          state_d     = S_GAP;
          pend_d      = rr_pick(req, last_q);
          pend_park_d = 1'b0;
        end
      end

      S_OWN: begin
        tx_d = tx_now;
`ifdef PCI_ARB_TIMEOUT_EN
        if (!tx_now && bus_idle) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) timed_out = 1'b1;
        end
`endif
        if (timed_out) begin
          // The idle owner is left out of this arbitration round.
          arb_req = req & ~owner_bit;
          rearb   = 1'b1;
        end else if (!req[owner_q] || (tx_now && |(req & ~owner_bit))) begin
          rearb = 1'b1;
        end

        if (rearb) begin
          if (|arb_req) begin
            win = rr_pick(arb_req, last_q);
            if (win != owner_q) begin
              state_d     = S_GAP;
              pend_d      = win;
              pend_park_d = 1'b0;
            end
          end else if (owner_q == PARK_IDX) begin
            // Owner is the park master: keep its grant, just relabel as parked.
            state_d = S_PARK;
          end else begin
            state_d     = S_GAP;
            pend_park_d = 1'b1;
          end
        end

        if (state_d != S_OWN) begin
          tx_d = 1'b0;
`ifdef PCI_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      S_GAP: begin
        if (pend_park_q) begin
          state_d = S_PARK;
          owner_d = PARK_IDX;
        end else if (req[pend_q]) begin
          state_d = S_OWN;
          owner_d = pend_q;
          last_d  = pend_q;
        end else begin
          // Latched winner withdrew during the gap.
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    gnt_d = '1;
    vld_d = 1'b0;
    if (state_d == S_OWN || state_d == S_PARK) begin
      gnt_d[owner_d] = 1'b0;
      vld_d          = 1'b1;
    end
  end

  // State, arbitration history and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= PARK_IDX;
      last_q      <= LAST_RST;
      pend_q      <= PARK_IDX;
      pend_park_q <= 1'b0;
      tx_q        <= 1'b0;
      gnt_q       <= '1;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      pend_park_q <= pend_park_d;
      tx_q        <= tx_d;
      gnt_q       <= gnt_d;
      vld_q       <= vld_d;
    end
  end

`ifdef PCI_ARB_TIMEOUT_EN
  // Idle-cycle counter for the current owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign GNT_n     = gnt_q;
  assign owner     = owner_q;
  assign owner_vld = vld_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter (N_MASTERS=4, PARK_MASTER=0).
// The reference model tracks who holds the bus as a plain integer.
module tb_pci_bus_arbiter;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] REQ_n;
  logic       FRAME_n;
  logic       IRDY_n;
  logic [3:0] GNT_n;
  logic [1:0] owner;
  logic       owner_vld;

  int n_tests = 0;
  int n_fail  = 0;

  pci_bus_arbiter #(
    .N_MASTERS  (N),
    .PARK_MASTER(PARK),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .REQ_n    (REQ_n),
    .FRAME_n  (FRAME_n),
    .IRDY_n   (IRDY_n),
    .GNT_n    (GNT_n),
    .owner    (owner),
    .owner_vld(owner_vld)
  );

  always #5 clk = ~clk;

  // Reference model: holder index (-1 = none), parked flag, pending gap target
  int m_hold, m_last, m_cnt, m_tgt;
  bit m_parked, m_gap, m_tx;

  function automatic int rr(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_hold < 0) ? 4'hF : ~(4'b0001 << m_hold);
  endfunction

  task automatic model_reset();
    m_hold = -1; m_last = N - 1; m_cnt = 0; m_tgt = -1;
    m_parked = 0; m_gap = 0; m_tx = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic fr, input logic ir);
    bit tx, expired, leave;
    logic [3:0] others, cand;
    int nxt;
    expired = 0; leave = 0;
    if (m_gap) begin
      m_gap = 0;
      if (m_tgt < 0) begin m_hold = PARK; m_parked = 1; end
      else if (r[m_tgt]) begin m_hold = m_tgt; m_parked = 0; m_last = m_tgt; end
      else m_hold = -1;
    end else if (m_hold < 0) begin
      if (r != 0) begin m_hold = rr(r, m_last); m_last = m_hold; m_parked = 0; end
      else begin m_hold = PARK; m_parked = 1; end
    end else if (m_parked) begin
      if (r == (4'b0001 << PARK)) begin m_parked = 0; m_last = PARK; end
      else if (r != 0) begin m_gap = 1; m_tgt = rr(r, m_last); m_hold = -1; m_parked = 0; end
    end else begin
      tx = m_tx || !fr;
      others = r & ~(4'b0001 << m_hold);
`ifdef PCI_ARB_TIMEOUT_EN
      if (!tx && fr && ir) begin m_cnt++; if (m_cnt >= TMO) expired = 1; end
`endif
      if (expired || !r[m_hold] || (tx && others != 0)) begin
        cand = expired ? others : r;
        if (cand != 0) begin
          nxt = rr(cand, m_last);
          if (nxt != m_hold) begin m_gap = 1; m_tgt = nxt; m_hold = -1; leave = 1; end
        end else if (m_hold == PARK) begin
          m_parked = 1; leave = 1;
        end else begin
          m_gap = 1; m_tgt = -1; m_hold = -1; leave = 1;
        end
      end
      m_tx = leave ? 1'b0 : tx;
      if (leave) m_cnt = 0;
    end
  endtask

  // Apply inputs for one clock, advance the model, settle just after the edge.
  task automatic step(input logic [3:0] rq, input logic fr, input logic ir);
    REQ_n = rq; FRAME_n = fr; IRDY_n = ir;
    @(posedge clk);
    model_step(~rq, fr, ir);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; REQ_n = 4'hF; FRAME_n = 1'b1; IRDY_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL reset_gnt: got %b want 1111", GNT_n); end
    n_tests++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", owner_vld); end
    n_tests++; if (owner !== 2'(PARK)) begin n_fail++; $display("FAIL reset_owner: got %0d want %0d", owner, PARK); end
    rst_n = 1'b1; model_reset();
    step(4'hF, 1, 1);
    n_tests++; if (GNT_n !== 4'b1110) begin n_fail++; $display("FAIL park_gnt: got %b want 1110", GNT_n); end
    n_tests++; if (owner !== 2'd0 || owner_vld !== 1'b1) begin n_fail++; $display("FAIL park_owner: got %0d/%b want 0/1", owner, owner_vld); end
  endtask

  task automatic test_park_to_gap();
    step(4'b1011, 1, 1);
    n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL park_gap: got %b want 1111", GNT_n); end
    step(4'b1011, 1, 1);
    n_tests++; if (GNT_n !== 4'b1011) begin n_fail++; $display("FAIL park_own2: got %b want 1011", GNT_n); end
    n_tests++; if (owner !== 2'd2) begin n_fail++; $display("FAIL park_owner2: got %0d want 2", owner); end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    step(4'b0000, 1, 1);
    for (int i = 0; i <= 4; i++) begin
      want = ~(4'b0001 << (i % 4));
      n_tests++; if (GNT_n !== want) begin n_fail++; $display("FAIL rot_own%0d: got %b want %b", i, GNT_n, want); end
      n_tests++; if (owner !== 2'(i % 4)) begin n_fail++; $display("FAIL rot_owner%0d: got %0d want %0d", i, owner, i % 4); end
      if (i < 4) begin
        step(4'b0000, 0, 1);
        n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL rot_gap%0d: got %b want 1111", i, GNT_n); end
        step(4'b0000, 1, 1);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    step(4'b1101, 1, 1);
    n_tests++; if (GNT_n !== 4'b1101) begin n_fail++; $display("FAIL pre_own1: got %b want 1101", GNT_n); end
    step(4'b1101, 0, 1);
    n_tests++; if (GNT_n !== 4'b1101) begin n_fail++; $display("FAIL pre_hold1: got %b want 1101", GNT_n); end
    step(4'b0101, 0, 0);
    n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL pre_gap: got %b want 1111", GNT_n); end
    step(4'b0101, 0, 0);
    n_tests++; if (GNT_n !== 4'b0111) begin n_fail++; $display("FAIL pre_own3: got %b want 0111", GNT_n); end
    n_tests++; if (owner !== 2'd3) begin n_fail++; $display("FAIL pre_owner3: got %0d want 3", owner); end
  endtask

`ifdef PCI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    step(4'b1011, 1, 1);
    n_tests++; if (GNT_n !== 4'b1011) begin n_fail++; $display("FAIL tmo_own2: got %b want 1011", GNT_n); end
    for (int i = 1; i <= TMO - 1; i++) begin
      step(4'b1010, 1, 1);
      n_tests++; if (GNT_n !== 4'b1011) begin n_fail++; $display("FAIL tmo_hold%0d: got %b want 1011", i, GNT_n); end
    end
    step(4'b1010, 1, 1);
    n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL tmo_gap: got %b want 1111", GNT_n); end
    step(4'b1010, 1, 1);
    n_tests++; if (GNT_n !== 4'b1110) begin n_fail++; $display("FAIL tmo_own0: got %b want 1110", GNT_n); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    step(4'b1011, 1, 1);
    for (int i = 0; i < 3 * TMO; i++) begin
      step(4'b1010, 1, 1);
      n_tests++; if (GNT_n !== 4'b1011) begin n_fail++; $display("FAIL hold2_%0d: got %b want 1011", i, GNT_n); end
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    step(4'b1011, 1, 1);
    step(4'b1011, 0, 1);
    step(4'b1011, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (GNT_n !== 4'hF) begin n_fail++; $display("FAIL arst_gnt: got %b want 1111", GNT_n); end
    n_tests++; if (owner_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b want 0", owner_vld); end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
    step(4'b0000, 1, 1);
    n_tests++; if (GNT_n !== 4'b1110 || owner !== 2'd0) begin n_fail++; $display("FAIL arst_first: got %b/%0d want 1110/0", GNT_n, owner); end
  endtask

  task automatic test_random();
    logic [3:0] rq;
    logic fr, ir;
    int prev;
    do_reset();
    rq = 4'hF; prev = -1;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(1, 0) == 1) rq = 4'($urandom);
      fr = ($urandom_range(3, 0) != 0);
      ir = ($urandom_range(3, 0) != 0);
      step(rq, fr, ir);
      n_tests++; if (GNT_n !== exp_gnt()) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, GNT_n, exp_gnt()); end
      if (m_hold >= 0) begin
        n_tests++; if (owner !== 2'(m_hold)) begin n_fail++; $display("FAIL rnd_owner@%0d: got %0d want %0d", c, owner, m_hold); end
      end
      n_tests++; if ($countones(~GNT_n) > 1) begin n_fail++; $display("FAIL rnd_overlap@%0d: got %b want at most one low", c, GNT_n); end
      if (owner_vld && prev >= 0) begin
        n_tests++; if (int'(owner) != prev) begin n_fail++; $display("FAIL rnd_nogap@%0d: got owner %0d after %0d want gap", c, owner, prev); end
      end
      prev = owner_vld ? int'(owner) : -1;
    end
  endtask

  initial begin
    rst_n = 1'b0; REQ_n = 4'hF; FRAME_n = 1'b1; IRDY_n = 1'b1;
    model_reset();
    test_reset();
    test_park_to_gap();
    test_rotation();
    test_preempt();
`ifdef PCI_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
